test_sequencer: RTL and testbench

Hardware sequencer for the production-test board image. It sits between the keyboard command decoder and the four self-test engines: fast SRAM, slow SRAM, SD slot and SPI flash. On a start request it runs the enabled tests one after another. For each test it pulses that engine's init line, watches its progress flag with timeouts, and latches a pass/fail/timeout verdict per test for the message updater.

---
 rtl/test_sequencer_if.sv | 33 +++
 rtl/test_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_test_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/test_sequencer_if.sv
// test_sequencer_if: command/engine bundle between the keyboard decoder,
// the four self-test engines and the test sequencer.
//   start    : one-cycle run request (clk-synchronous)
//   enable   : per-test mask, sampled on an accepted start
//   progress : test_in_progress from each engine (asynchronous)
//   result   : test_result from each engine (asynchronous)
//   init     : init pulse to each engine
//   busy/done/current/pass/timeout/all_pass : sequencer status
// Index 0 = SRAM fast, 1 = SRAM slow, 2 = SD, 3 = flash.
// master = driver side (decoder + engines), slave = sequencer.
interface test_sequencer_if;
    logic       start;
    logic [3:0] enable;
    logic [3:0] progress;
    logic [3:0] result;
    logic [3:0] init;
    logic       busy;
    logic       done;
    logic [1:0] current;
    logic [3:0] pass;
    logic [3:0] timeout;
    logic       all_pass;

    modport master (
        output start, enable, progress, result,
        input  init, busy, done, current, pass, timeout, all_pass
    );

    modport slave (
        input  start, enable, progress, result,
        output init, busy, done, current, pass, timeout, all_pass
    );
endinterface

// File: rtl/test_sequencer.sv
// test_sequencer: runs the enabled self-tests one after another. For each
// test it pulses the engine's init line, waits (with timeouts) for the
// engine's progress flag to rise and fall, and latches a pass or timeout
// verdict per test.
// Ports:
//   clk : system clock (clk7 domain)
//   rst : asynchronous active-high reset
//   bus : test_sequencer_if.slave (start/enable/progress/result in,
//         init/busy/done/current/pass/timeout/all_pass out)

// Per-engine 2-flop synchronizer for the asynchronous progress/result flags.
module test_sequencer_lane_sync (
    input  logic clk,
    input  logic rst,
    input  logic progress_in,
    input  logic result_in,
    output logic progress_s,
    output logic result_s
);
    logic [1:0] p_ff, r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ff <= '0;
            r_ff <= '0;
        end else begin
            p_ff <= {p_ff[0], progress_in};
            r_ff <= {r_ff[0], result_in};
        end
    end

    assign progress_s = p_ff[1];
    assign result_s   = r_ff[1];
endmodule

module test_sequencer #(
    parameter int INIT_CYCLES   = 16,
    parameter int START_TIMEOUT = 1024,
    parameter int RUN_TIMEOUT   = 14000000,
    parameter int CW            = 24
) (
    input logic             clk,
    input logic             rst,
    test_sequencer_if.slave bus
);
    localparam int NUM_TESTS = 4;
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ICW-1:0] INIT_LAST  = ICW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0]  START_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0]  RUN_LAST   = CW'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, INIT, WAIT_START, WAIT_END, NEXT, DONE} state_t;

    state_t                 state, state_nxt;
    logic [NUM_TESTS-1:0]   mask, mask_nxt;
    logic [1:0]             current, cur_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [ICW-1:0]         icnt, icnt_nxt;
    logic [NUM_TESTS-1:0]   pass_q, pass_nxt;
    logic [NUM_TESTS-1:0]   to_q, to_nxt;
    logic [NUM_TESTS-1:0]   init_q;
    logic [NUM_TESTS-1:0]   p_s, r_s;
    logic [2:0]             first_sel, next_sel;

    for (genvar g = 0; g < NUM_TESTS; g++) begin : g_lane
        test_sequencer_lane_sync u_sync (
            .clk         (clk),
            .rst         (rst),
            .progress_in (bus.progress[g]),
            .result_in   (bus.result[g]),
            .progress_s  (p_s[g]),
            .result_s    (r_s[g])
        );
    end

    // Lowest set bit of m at index >= from; result is {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_TESTS; i++)
            if (!r[2] && m[i] && (3'(i) >= from))
                r = {1'b1, 2'(i)};
        return r;
    endfunction

    assign first_sel = pick(bus.enable, 3'd0);
    assign next_sel  = pick(mask, {1'b0, current} + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mask    <= '0;
            current <= '0;
            cnt     <= '0;
            icnt    <= '0;
            pass_q  <= '0;
            to_q    <= '0;
            init_q  <= '0;
        end else begin
            state   <= state_nxt;
            mask    <= mask_nxt;
            current <= cur_nxt;
            cnt     <= cnt_nxt;
            icnt    <= icnt_nxt;
            pass_q  <= pass_nxt;
            to_q    <= to_nxt;
            // init is registered off the next state so it is glitch-free
            // and lines up exactly with the INIT state.
            init_q  <= (state_nxt == INIT) ? (4'b0001 << cur_nxt) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        cur_nxt   = current;
        cnt_nxt   = cnt;
        icnt_nxt  = icnt;
        pass_nxt  = pass_q;
        to_nxt    = to_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    mask_nxt = bus.enable;
                    pass_nxt = '0;
                    to_nxt   = '0;
                    if (!first_sel[2]) begin
                        state_nxt = DONE;
                    end else begin
                        cur_nxt   = first_sel[1:0];
                        icnt_nxt  = '0;
                        state_nxt = INIT;
                    end
                end
            end
            INIT: begin
                if (icnt == INIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_START;
                end else begin
                    icnt_nxt = icnt + 1'b1;
                end
            end
            WAIT_START: begin
                // progress is tested first so it wins over a same-cycle timeout
                if (p_s[current]) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_END;
                end else if (cnt == START_LAST) begin
                    to_nxt[current] = 1'b1;
                    state_nxt       = NEXT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_END: begin
                if (!p_s[current]) begin
                    pass_nxt[current] = r_s[current];
                    state_nxt         = NEXT;
                end else if (cnt == RUN_LAST) begin
                    to_nxt[current] = 1'b1;
                    state_nxt       = NEXT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            NEXT: begin
                if (next_sel[2]) begin
                    cur_nxt   = next_sel[1:0];
                    icnt_nxt  = '0;
                    state_nxt = INIT;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.init     = init_q;
    assign bus.busy     = (state == INIT) || (state == WAIT_START) ||
                          (state == WAIT_END) || (state == NEXT);
    assign bus.done     = (state == DONE);
    assign bus.current  = current;
    assign bus.pass     = pass_q;
    assign bus.timeout  = to_q;
    assign bus.all_pass = (state == DONE) && (&(pass_q | ~mask));
endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: behavioural engine models, an init-pulse
// monitor and a per-run verdict model derived from each engine's behaviour.
module tb_test_sequencer;
    localparam int IC = 4;
    localparam int ST = 8;
    localparam int RT = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    test_sequencer_if sif();

    test_sequencer #(
        .INIT_CYCLES(IC), .START_TIMEOUT(ST), .RUN_TIMEOUT(RT), .CW(24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine behaviour: after its init falls, wait dly cycles, raise progress
    // with result res, hold hold cycles, then drop. never: never raises;
    // stuck: never drops.
    int dly[4], hold[4];
    bit res[4], never[4], stuck[4];
    int phase[4], ctr[4];
    logic [3:0] init_prev = '0;
    bit eng_clr = 1'b0;

    initial begin
        sif.start = 1'b0; sif.enable = '0; sif.progress = '0; sif.result = '0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (eng_clr) begin
                phase[k] = 0; sif.progress[k] = 1'b0; sif.result[k] = 1'b0;
            end else begin
                if (init_prev[k] && !sif.init[k] && !never[k]) begin
                    phase[k] = 1; ctr[k] = dly[k];
                end
                if (phase[k] == 1) begin
                    if (ctr[k] == 0) begin
                        sif.progress[k] = 1'b1; sif.result[k] = res[k];
                        phase[k] = 2; ctr[k] = hold[k];
                    end else ctr[k]--;
                end else if (phase[k] == 2 && !stuck[k]) begin
                    if (ctr[k] <= 1) begin
                        sif.progress[k] = 1'b0; phase[k] = 3;
                    end else ctr[k]--;
                end
            end
        end
        init_prev = sif.init;
    end

    // Init monitor: order and width of every init pulse.
    int seq_q[$], wid_q[$];
    int mon_w = 0;
    bit init_bad = 1'b0;
    logic [3:0] mon_prev = '0;

    always @(negedge clk) begin
        if (eng_clr) begin
            seq_q.delete(); wid_q.delete(); mon_w = 0; init_bad = 1'b0; mon_prev = '0;
        end else begin
            if (sif.init != 0) begin
                if ($countones(sif.init) != 1) init_bad = 1'b1;
                if (sif.init != mon_prev) begin
                    if (mon_prev != 0) wid_q.push_back(mon_w);
                    for (int k = 0; k < 4; k++) if (sif.init[k]) seq_q.push_back(k);
                    mon_w = 1;
                end else mon_w++;
            end else if (mon_prev != 0) begin
                wid_q.push_back(mon_w);
            end
            mon_prev = sif.init;
        end
    end

    task automatic set_all(input int d, input int h, input bit r);
        for (int k = 0; k < 4; k++) begin
            dly[k] = d; hold[k] = h; res[k] = r; never[k] = 0; stuck[k] = 0;
        end
    endtask

    task automatic clear_engines();
        eng_clr = 1'b1;
        @(negedge clk);
        #1 eng_clr = 1'b0;
    endtask

    // One complete run; lat = negedges from start acceptance to done seen.
    task automatic run_seq(input string tag, input logic [3:0] en, input bit poke, output int lat);
        logic [3:0] ep, et;
        int n, c;
        bit poked;
        clear_engines();
        @(negedge clk);
        sif.enable = en; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        chk({tag, "_busy"}, {31'd0, sif.busy}, {31'd0, en != 0});
        poked = 1'b0;
        c = 0;
        while (c < 3000 && !sif.done) begin
            if (sif.start) sif.start = 1'b0;
            else if (poke && !poked && sif.current == 2'd1 && sif.init == 0 &&
                     phase[1] == 2 && ctr[1] <= hold[1] - 3) begin
                sif.start = 1'b1; sif.enable = ~en; poked = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        sif.start = 1'b0;
        lat = c + 1;
        chk({tag, "_done"}, {31'd0, sif.done}, 32'd1);
        if (poke) chk({tag, "_poked"}, {31'd0, poked}, 32'd1);
        // Reference verdicts from engine behaviour.
        ep = '0; et = '0;
        for (int k = 0; k < 4; k++)
            if (en[k]) begin
                if (never[k] || stuck[k]) et[k] = 1'b1;
                else ep[k] = res[k];
            end
        chk({tag, "_pass"}, {28'd0, sif.pass}, {28'd0, ep});
        chk({tag, "_timeout"}, {28'd0, sif.timeout}, {28'd0, et});
        chk({tag, "_all_pass"}, {31'd0, sif.all_pass}, {31'd0, &(ep | ~en)});
        chk({tag, "_busy_end"}, {31'd0, sif.busy}, 32'd0);
        chk({tag, "_init_onehot"}, {31'd0, init_bad}, 32'd0);
        chk({tag, "_npulses"}, seq_q.size(), $countones(en));
        n = 0;
        for (int k = 0; k < 4; k++)
            if (en[k] && n < seq_q.size()) begin
                chk({tag, "_order"}, seq_q[n], k);
                if (n < wid_q.size()) chk({tag, "_width"}, wid_q[n], IC);
                else chk({tag, "_width_missing"}, 0, 1);
                n++;
            end
        sif.enable = en;
    endtask

    initial begin
        int lat, c;
        logic [3:0] en;
        set_all(2, 10, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_init", {28'd0, sif.init}, 0);
        chk("rst_status", {21'd0, sif.busy, sif.done, sif.current, sif.pass, sif.timeout, sif.all_pass}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", {31'd0, sif.done}, 0);

        // Empty mask: done one cycle after start, no init.
        run_seq("empty", 4'b0000, 1'b0, lat);
        chk("empty_lat", lat, 1);

        set_all(2, 10, 1'b1);
        run_seq("allpass", 4'b1111, 1'b0, lat);

        set_all(2, 10, 1'b1); never[2] = 1;
        run_seq("start_to", 4'b0100, 1'b0, lat);
        chk("start_to_lat", {31'd0, (lat >= 13 && lat <= 17)}, 32'd1);

        set_all(2, 10, 1'b1); stuck[3] = 1;
        run_seq("run_to", 4'b1000, 1'b0, lat);

        set_all(2, 10, 1'b1); res[0] = 0;
        run_seq("fail0", 4'b0001, 1'b0, lat);

        set_all(1, 6, 1'b1);
        run_seq("skip", 4'b1010, 1'b0, lat);

        set_all(2, 15, 1'b1);
        run_seq("busy_start", 4'b0111, 1'b1, lat);

        // Asynchronous reset while init[2] is high.
        set_all(2, 5, 1'b1);
        clear_engines();
        sif.enable = 4'b0111; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        c = 0;
        while (c < 500 && !sif.init[2]) begin @(negedge clk); c++; end
        chk("mid_init2_seen", {31'd0, sif.init[2]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_init", {28'd0, sif.init}, 0);
        chk("mid_rst_status", {21'd0, sif.busy, sif.done, sif.current, sif.pass, sif.timeout, sif.all_pass}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("after_rst", 4'b0111, 1'b0, lat);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 4; k++) begin
                int m;
                m = $urandom_range(0, 9);
                never[k] = (m == 0);
                stuck[k] = (m == 1);
                dly[k]   = $urandom_range(0, 3);
                hold[k]  = $urandom_range(1, 20);
                res[k]   = $urandom_range(0, 1);
            end
            en = 4'($urandom_range(0, 15));
            run_seq("rand", en, 1'b0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
